// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared definitions for the pipeline stall/flush sequencer.
//               Holds the sequencer state encoding, the hard-wired zero
//               register index and the bit layout of the 22-bit stage
//               control word carried through ID/EX, EX/MEM and MEM/WB.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

    // r0 reads as zero, so writing it never creates a dependency
    localparam int REG_ZERO = 0;

    // Stage control word layout
    localparam int CW_WIDTH       = 22;
    localparam int CW_ALU_OP_LSB  = 0;   // [3:0]
    localparam int CW_ALU_OP_MSB  = 3;
    localparam int CW_ALU_SRC     = 4;
    localparam int CW_REG_DST_LSB = 5;   // [6:5]
    localparam int CW_REG_DST_MSB = 6;
    localparam int CW_BRANCH      = 7;
    localparam int CW_JUMP        = 8;
    localparam int CW_MEM_READ    = 9;
    localparam int CW_MEM_WRITE   = 10;
    localparam int CW_MEM_SIZE_LSB = 11; // [12:11]
    localparam int CW_MEM_SIZE_MSB = 12;
    localparam int CW_MEM_SIGNED  = 13;
    localparam int CW_REG_WRITE   = 14;
    localparam int CW_MEM_TO_REG  = 15;
    localparam int CW_SHIFT_LSB   = 16;  // [17:16]
    localparam int CW_SHIFT_MSB   = 17;
    localparam int CW_IMM_SEL_LSB = 18;  // [20:18]
    localparam int CW_IMM_SEL_MSB = 20;
    localparam int CW_VALID       = 21;

    // Control word loaded by a bubble: no writes, no memory access, invalid
    localparam logic [CW_WIDTH-1:0] CW_NOP = '0;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_controller_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in EX is a load whose destination is read by the
//               instruction in ID.
// Ports       : id_rs, id_rt  - source registers of the ID instruction
//               id_uses_rt    - ID instruction actually reads rt
//               ex_rd         - destination register of the EX instruction
//               ex_mem_read   - EX instruction is a load
//               load_use      - hazard present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              load_use
);

    logic w_rd_real;
    logic w_rs_hit;
    logic w_rt_hit;

    always_comb begin
        w_rd_real = (ex_rd != REG_AW'(REG_ZERO));
        w_rs_hit  = (ex_rd == id_rs);
        w_rt_hit  = id_uses_rt && (ex_rd == id_rt);
        load_use  = ex_mem_read && w_rd_real && (w_rs_hit || w_rt_hit);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Stall/flush sequencer for the 5-stage pipeline. Produces the
//               PC and stage-register enables plus flush/bubble controls as a
//               Mealy function of state and inputs, tracks data-memory waits
//               with a timeout watchdog, and counts stalled cycles.
// Ports       : clk, reset            - clock, async active-high reset
//               id_*/ex_*             - hazard inputs from ID and EX
//               ex_branch_taken       - taken branch/jump in EX
//               mem_req, mem_ready    - data-memory handshake from MEM
//               pc_en, ifid_en        - front-end enables
//               ifid_flush            - NOP into IF/ID
//               idex_bubble           - zero control word into ID/EX
//               exmem_en, memwb_en    - back-end enables
//               mem_error             - sticky memory-timeout flag
//               stall_count           - saturating count of pc_en=0 cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              mem_error,
    output logic [CNT_W-1:0]  stall_count
);

    // Wait counter only has to reach MEM_TIMEOUT-1
    localparam int               WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e       state_q,       state_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              mem_error_q,   mem_error_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic w_load_use;
    logic w_mem_pass;   // memory is not holding the pipeline this cycle

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (w_load_use)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_error_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_error_q   <= mem_error_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        w_mem_pass  = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    w_mem_pass = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    w_mem_pass = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ERROR;
                    mem_error_d = 1'b1;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ERROR: begin
                // Dead until reset; mem_ready is deliberately ignored
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (w_mem_pass) begin
            if (ex_branch_taken) begin
                // Squash IF and ID; a load-use on the squashed ID op is moot
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else if (w_load_use) begin
                // Hold IF/ID one cycle while the load advances into MEM
                idex_bubble = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end

        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
        end

        stall_count_d = stall_count_q;
        if (!pc_en && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    assign mem_error   = mem_error_q;
    assign stall_count = stall_count_q;

endmodule : pipeline_stall_controller
`default_nettype wire
